sha256_msg_sched: RTL

//  Sequential SHA-256 message schedule generator. It is the producer side of the
//  W_t stream that the sigma functions and the compression rounds consume.
//  - Accepts one 512-bit block as 16 big-endian 32-bit words, W0..W15.
//  - Emits W0..W(ROUNDS-1), one word per transfer, on a valid/ready stream.
//  - Keeps a 16-word sliding window and derives W16+ using lsigma0/lsigma1 logic.

---
 rtl/sha256_msg_sched_if.sv | 30 +++
 rtl/sha256_msg_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched_if
// Bundles the two streams of the SHA-256 message schedule generator.
//   Input stream  : in_valid / in_ready / in_word        (message words W0..W15)
//   Output stream : w_valid / w_ready / w_word / w_idx   (schedule words W_t)
//   blk_done      : pulse that accompanies the accept of the last W_t of a block
// Modports:
//   master - the schedule generator itself (it masters the W_t stream)
//   slave  - the environment: message source and W_t consumer
// ---------------------------------------------------------------------------
interface sha256_msg_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_idx;
    logic        blk_done;

    modport master (
        input  in_valid, in_word, w_ready,
        output in_ready, w_valid, w_word, w_idx, blk_done
    );

    modport slave (
        output in_valid, in_word, w_ready,
        input  in_ready, w_valid, w_word, w_idx, blk_done
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// Sequential SHA-256 message schedule generator. Takes the 16 big-endian
// message words of one 512-bit block, forwards them as W0..W15, then expands
// W16..W(ROUNDS-1) from a 16-word sliding window, one word per transfer.
// Parameters:
//   ROUNDS   number of W words emitted per block (17..64, 64 for FIPS 180-4)
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous reset, active low
//   io_sched   stream bundle (master side), see sha256_msg_sched_if
// ---------------------------------------------------------------------------
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input logic                clk,
    input logic                rst_n,
    sha256_msg_sched_if.master io_sched
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam logic [6:0] LAST_LOAD_T = 7'd15;
    localparam logic [6:0] LAST_T      = 7'(ROUNDS - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_t;
    logic [31:0] r_win [16];
    logic [31:0] r_outWord;
    logic [5:0]  r_outIdx;
    logic        r_outValid;

    logic        w_slotFree;
    logic        w_inAccept;
    logic        w_outAccept;
    logic        w_shiftEn;
    logic [31:0] w_shiftIn;
    logic [31:0] w_newW;

    function automatic logic [31:0] f_ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return f_ror(x, 7) ^ f_ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return f_ror(x, 17) ^ f_ror(x, 19) ^ (x >> 10);
    endfunction

    // The output register can take a new word when it is empty or its
    // current word is being consumed this cycle.
    assign w_slotFree  = !r_outValid || io_sched.w_ready;
    assign w_outAccept = r_outValid && io_sched.w_ready;
    assign w_inAccept  = (r_state == ST_LOAD) && w_slotFree && io_sched.in_valid;

    // win[15] is W(t-1) and win[0] is W(t-16); the sum wraps mod 2^32.
    assign w_newW = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    // Both loading and expanding push exactly one word into the window.
    assign w_shiftEn = w_inAccept || ((r_state == ST_EXPAND) && w_slotFree);
    assign w_shiftIn = (r_state == ST_LOAD) ? io_sched.in_word : w_newW;

    assign io_sched.in_ready = (r_state == ST_LOAD) && w_slotFree;
    assign io_sched.w_valid  = r_outValid;
    assign io_sched.w_word   = r_outWord;
    assign io_sched.w_idx    = r_outIdx;
    assign io_sched.blk_done = (r_state == ST_DRAIN) && w_outAccept;

    // Sliding window: oldest word at index 0, newest enters at index 15.
    // A stalled output register freezes the window as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_shiftEn) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i + 1];
            end
            r_win[15] <= w_shiftIn;
        end
    end

    // Sequencer plus output register. LOAD forwards the 16 message words,
    // EXPAND derives the rest, DRAIN waits for the last word to be taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_t        <= '0;
            r_outWord  <= '0;
            r_outIdx   <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_inAccept) begin
                        r_outWord  <= io_sched.in_word;
                        r_outIdx   <= r_t[5:0];
                        r_outValid <= 1'b1;
                        r_t        <= r_t + 7'd1;
                        if (r_t == LAST_LOAD_T) begin
                            r_state <= ST_EXPAND;
                        end
                    end else if (w_outAccept) begin
                        r_outValid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    if (w_slotFree) begin
                        r_outWord  <= w_newW;
                        r_outIdx   <= r_t[5:0];
                        r_outValid <= 1'b1;
                        r_t        <= r_t + 7'd1;
                        if (r_t == LAST_T) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_outAccept) begin
                        r_outValid <= 1'b0;
                        r_outWord  <= '0;
                        r_outIdx   <= '0;
                        r_t        <= '0;
                        r_state    <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
